// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: runs the 6502 interrupt entry sequence for NMI, BRK and IRQ.
// Pushes PCH, PCL and PS onto the stack page, sets the I flag, reads the
// two-byte vector and loads it into PC. While busy it owns the register-file
// write enables and the memory port.
module interrupt_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        boundary,
  input  logic        nmi,
  input  logic        irq,
  input  logic        brk_req,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic [7:0]  ps,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        we_sp,
  output logic [7:0]  sp_out,
  output logic        we_pc,
  output logic [15:0] pc_out,
  output logic        we_ps,
  output logic [7:0]  ps_out,
  output logic        done,
  output logic [1:0]  kind
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PCH,
    ST_PUSH_PCL,
    ST_PUSH_PS,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_LOAD_PC
  } state_t;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_IRQ  = 2'b01;
  localparam logic [1:0] KIND_BRK  = 2'b10;
  localparam logic [1:0] KIND_NMI  = 2'b11;

  state_t      state_q, state_d;
  logic        nmi_d_q, nmi_d_d;
  logic        nmi_pending_q, nmi_pending_d;
  logic [1:0]  kind_q, kind_d;
  logic [7:0]  vec_lo_q, vec_lo_d;

  logic        nmi_edge;
  logic [15:0] stack_addr;
  logic [15:0] vec_addr;
  logic [7:0]  pushed_ps;

  assign nmi_edge   = nmi & ~nmi_d_q;
  assign stack_addr = {STACK_PAGE, sp};
  assign vec_addr   = (kind_q == KIND_NMI) ? NMI_VEC : IRQ_VEC;
  assign kind       = kind_q;

  // State, NMI edge history, pending flag, latched source and vector low byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      nmi_d_q       <= 1'b0;
      nmi_pending_q <= 1'b0;
      kind_q        <= KIND_NONE;
      vec_lo_q      <= 8'h00;
    end else begin
      state_q       <= state_d;
      nmi_d_q       <= nmi_d_d;
      nmi_pending_q <= nmi_pending_d;
      kind_q        <= kind_d;
      vec_lo_q      <= vec_lo_d;
    end
  end

  // Next state: accept by priority at a boundary, then walk the fixed sequence
  always_comb begin
    state_d       = state_q;
    nmi_d_d       = nmi;
    nmi_pending_d = nmi_pending_q | nmi_edge;
    kind_d        = kind_q;
    vec_lo_d      = vec_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (boundary) begin
          if (nmi_pending_q) begin
            kind_d        = KIND_NMI;
            nmi_pending_d = nmi_edge;
            state_d       = ST_PUSH_PCH;
          end else if (brk_req) begin
            kind_d  = KIND_BRK;
            state_d = ST_PUSH_PCH;
          end else if (irq && !ps[2]) begin
            kind_d  = KIND_IRQ;
            state_d = ST_PUSH_PCH;
          end
        end
      end
      ST_PUSH_PCH: state_d = ST_PUSH_PCL;
      ST_PUSH_PCL: state_d = ST_PUSH_PS;
      ST_PUSH_PS:  state_d = ST_VEC_LO;
      ST_VEC_LO:   state_d = ST_VEC_HI;
      ST_VEC_HI: begin
        vec_lo_d = mem_rdata;
        state_d  = ST_LOAD_PC;
      end
      ST_LOAD_PC:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state and the live register-file inputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    we_sp     = 1'b0;
    sp_out    = 8'h00;
    we_pc     = 1'b0;
    pc_out    = 16'h0000;
    we_ps     = 1'b0;
    ps_out    = 8'h00;
    done      = 1'b0;
    pushed_ps    = ps | 8'h20;
    pushed_ps[4] = (kind_q == KIND_BRK);
    unique case (state_q)
      ST_PUSH_PCH: begin
        mem_addr  = stack_addr;
        mem_wdata = pc[15:8];
        mem_we    = 1'b1;
        we_sp     = 1'b1;
        sp_out    = sp - 8'd1;
      end
      ST_PUSH_PCL: begin
        mem_addr  = stack_addr;
        mem_wdata = pc[7:0];
        mem_we    = 1'b1;
        we_sp     = 1'b1;
        sp_out    = sp - 8'd1;
      end
      ST_PUSH_PS: begin
        mem_addr  = stack_addr;
        mem_wdata = pushed_ps;
        mem_we    = 1'b1;
        we_sp     = 1'b1;
        sp_out    = sp - 8'd1;
        we_ps     = 1'b1;
        ps_out    = ps | 8'h04;
      end
      ST_VEC_LO: begin
        mem_addr = vec_addr;
      end
      ST_VEC_HI: begin
        mem_addr = vec_addr + 16'd1;
      end
      ST_LOAD_PC: begin
        we_pc  = 1'b1;
        pc_out = {mem_rdata, vec_lo_q};
        done   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: acts as register file and memory around the
// sequencer and checks each interrupt entry against a transaction-level model.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        boundary, nmi, irq, brk_req;
  logic [15:0] pc_r;
  logic [7:0]  sp_r, ps_r, mem_rdata;
  logic        busy, mem_we, we_sp, we_pc, we_ps, done;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, sp_out, ps_out;
  logic [1:0]  kind;

  logic [7:0]  mem [0:65535];
  logic [23:0] wq [$];
  logic        pend_model;
  logic        obs_busy, obs_done, obs_we_pc;
  logic [1:0]  obs_kind;
  int          total = 0;
  int          bad = 0;

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .boundary(boundary), .nmi(nmi), .irq(irq),
    .brk_req(brk_req), .pc(pc_r), .sp(sp_r), .ps(ps_r), .mem_rdata(mem_rdata),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .we_sp(we_sp), .sp_out(sp_out), .we_pc(we_pc), .pc_out(pc_out),
    .we_ps(we_ps), .ps_out(ps_out), .done(done), .kind(kind)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs mid-cycle, then update register file and memory after the edge
  task automatic step();
    logic        w_mem, w_sp, w_pc, w_ps;
    logic [15:0] a, pcv;
    logic [7:0]  d, spv, psv;
    @(negedge clk);
    obs_busy = busy; obs_done = done; obs_we_pc = we_pc; obs_kind = kind;
    w_mem = mem_we; a = mem_addr; d = mem_wdata;
    w_sp = we_sp; spv = sp_out; w_pc = we_pc; pcv = pc_out; w_ps = we_ps; psv = ps_out;
    if (w_mem) wq.push_back({a, d});
    @(posedge clk);
    #1;
    if (w_mem) mem[a] = d;
    if (w_sp) sp_r = spv;
    if (w_pc) pc_r = pcv;
    if (w_ps) ps_r = psv;
    mem_rdata = mem[a];
  endtask

  // Registers a fresh NMI rising edge while idle
  task automatic apply_stimulus_nmi_edge();
    nmi = 1'b0;
    step();
    nmi = 1'b1;
    pend_model = 1'b1;
    step();
  endtask

  // Presents a boundary with the current request lines and checks the whole entry
  task automatic apply_stimulus(input string tag, input int nmi_rise_at, input logic drop_irq);
    logic [1:0]  exp_kind, kind_seen;
    logic [15:0] pc0, vec, exp_pc;
    logic [7:0]  sp0, ps0, exp_push_ps, a_lo;
    logic [7:0]  exp_d [3];
    int          done_step, busy_cnt, pcload_cnt;
    pc0 = pc_r; sp0 = sp_r; ps0 = ps_r;
    if (pend_model) exp_kind = 2'b11;
    else if (brk_req) exp_kind = 2'b10;
    else if (irq && !ps_r[2]) exp_kind = 2'b01;
    else exp_kind = 2'b00;
    vec = (exp_kind == 2'b11) ? 16'hFFFA : 16'hFFFE;
    exp_pc = {mem[vec + 16'd1], mem[vec]};
    exp_push_ps = ((ps0 | 8'h20) & 8'hEF) | ((exp_kind == 2'b10) ? 8'h10 : 8'h00);
    exp_d[0] = pc0[15:8]; exp_d[1] = pc0[7:0]; exp_d[2] = exp_push_ps;
    wq.delete();
    boundary = 1'b1;
    step();
    boundary = 1'b0;
    brk_req = 1'b0;
    if (drop_irq) irq = 1'b0;
    if (exp_kind == 2'b11) pend_model = 1'b0;
    if (exp_kind == 2'b00) begin
      step();
      check_output({tag, "_idle_busy"}, 32'(obs_busy), 32'h0);
      check_output({tag, "_idle_writes"}, 32'(wq.size()), 32'h0);
      check_output({tag, "_idle_done"}, 32'(obs_done), 32'h0);
      return;
    end
    done_step = 0; busy_cnt = 0; pcload_cnt = 0; kind_seen = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      if (k == nmi_rise_at && nmi == 1'b0) begin
        nmi = 1'b1;
        pend_model = 1'b1;
      end
      step();
      if (k == 1) kind_seen = obs_kind;
      if (obs_busy) busy_cnt++;
      if (obs_we_pc) pcload_cnt++;
      if (obs_done) begin
        done_step = k;
        break;
      end
    end
    check_output({tag, "_kind"}, 32'(kind_seen), 32'(exp_kind));
    check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd6);
    check_output({tag, "_done_cycle"}, 32'(done_step), 32'd6);
    check_output({tag, "_pc_loads"}, 32'(pcload_cnt), 32'd1);
    check_output({tag, "_writes"}, 32'(wq.size()), 32'd3);
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      a_lo = sp0 - 8'(i);
      check_output({tag, "_push_addr"}, 32'(wq[i][23:8]), 32'({8'h01, a_lo}));
      check_output({tag, "_push_data"}, 32'(wq[i][7:0]), 32'(exp_d[i]));
    end
    check_output({tag, "_sp"}, 32'(sp_r), 32'(8'(sp0 - 8'd3)));
    check_output({tag, "_ps"}, 32'(ps_r), 32'(ps0 | 8'h04));
    check_output({tag, "_pc"}, 32'(pc_r), 32'(exp_pc));
  endtask

  // Directed scenarios followed by randomized entries
  initial begin
    int mode, rise;
    reset = 1'b1; boundary = 1'b0; nmi = 1'b0; irq = 1'b0; brk_req = 1'b0;
    pc_r = 16'h0000; sp_r = 8'h00; ps_r = 8'h00; mem_rdata = 8'h00;
    pend_model = 1'b0;
    obs_busy = 1'b0; obs_done = 1'b0; obs_we_pc = 1'b0; obs_kind = 2'b00;
    for (int j = 0; j < 6; j++) mem[16'hFFFA + 16'(j)] = 8'h00;
    #2;
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_strobes", 32'({mem_we, we_sp, we_pc, we_ps, done}), 32'h0);
    check_output("rst_kind", 32'(kind), 32'h0);
    check_output("rst_addr", 32'(mem_addr), 32'h0);
    check_output("rst_data", 32'({mem_wdata, sp_out, ps_out}), 32'h0);
    check_output("rst_pc_out", 32'(pc_out), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] reset released");

    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    mem[16'hFFFA] = 8'h34; mem[16'hFFFB] = 8'hC2;
    pc_r = 16'h1234; sp_r = 8'hFF; ps_r = 8'h20; irq = 1'b1;
    apply_stimulus("irq", -1, 1'b1);
    check_output("irq_pc_8000", 32'(pc_r), 32'h8000);

    pc_r = 16'h2002; ps_r = 8'h30; brk_req = 1'b1;
    apply_stimulus("brk", -1, 1'b0);

    ps_r = 8'h20; irq = 1'b1;
    apply_stimulus("irq_nmi_mid", 2, 1'b1);
    apply_stimulus("nmi_after_irq", -1, 1'b0);
    check_output("nmi_vec_pc", 32'(pc_r), 32'hC234);
    apply_stimulus("nmi_cleared", -1, 1'b0);

    ps_r = 8'h34; irq = 1'b1;
    apply_stimulus("masked_irq", -1, 1'b0);
    apply_stimulus_nmi_edge();
    apply_stimulus("masked_nmi", -1, 1'b1);

    sp_r = 8'h01; ps_r = 8'h20; irq = 1'b1;
    apply_stimulus("sp_wrap", -1, 1'b1);

    nmi = 1'b0; pc_r = 16'h5555; sp_r = 8'h80; ps_r = 8'h20; irq = 1'b1;
    boundary = 1'b1;
    step();
    boundary = 1'b0; irq = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) nmi = 1'b1;
      step();
    end
    #2 reset = 1'b1;
    #1;
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_strobes", 32'({mem_we, we_sp, we_pc, we_ps, done}), 32'h0);
    check_output("midrst_addr", 32'(mem_addr), 32'h0);
    nmi = 1'b0;
    pend_model = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    check_output("midrst_kind", 32'(kind), 32'h0);
    apply_stimulus("post_reset_idle", -1, 1'b0);

    for (int it = 0; it < 30; it++) begin
      pc_r = 16'($urandom); sp_r = 8'($urandom); ps_r = 8'($urandom);
      for (int j = 0; j < 6; j++) mem[16'hFFFA + 16'(j)] = 8'($urandom);
      mode = int'($urandom_range(0, 3));
      irq = 1'b0; brk_req = 1'b0;
      if (mode == 2) apply_stimulus_nmi_edge();
      if (mode == 0 || mode == 3) irq = 1'b1;
      if (mode == 1 || mode == 3) brk_req = 1'b1;
      rise = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1;
      apply_stimulus("rnd", rise, 1'($urandom_range(0, 1)));
      irq = 1'b0; brk_req = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
